// File: rtl/fetch_queue.sv
// Fetch queue: buffers icache words and extracts PC-tagged 16/32-bit instructions at halfword alignment.
// Latency: an ack in cycle n gives instr_valid_o in cycle n+1 (no bypass); one request outstanding.
// Backpressure: req_o drops while the queue is full; instr_ready_i low holds the head instruction.
module fetch_queue #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  PC_RESET = 32'h8000_0000,
    localparam int unsigned     CW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            req_o,
    output logic [XLEN-1:0] req_addr_o,
    output logic            req_kill_o,
    input  logic            ack_i,
    input  logic [31:0]     rdata_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            instr_is_comp_o,
    input  logic            instr_ready_i,
    output logic [CW-1:0]   count_o
);

    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [31:0]     mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] fetch_addr;
    logic [XLEN-1:0] rd_pc;
    logic            run;

    logic [31:0]     head_word;
    logic [31:0]     next_word;
    logic [15:0]     p0;
    logic            off;
    logic            comp;
    logic            valid;
    logic            push;
    logic            pop;
    logic            free_head;
    logic            unused_pc_lsb;

    assign unused_pc_lsb = redirect_pc_i[0];

    assign head_word = mem[head];
    assign next_word = mem[head + PW'(1)];
    assign off       = rd_pc[1];
    assign p0        = off ? head_word[31:16] : head_word[15:0];
    assign comp      = (p0[1:0] != 2'b11);

    // A 32-bit parcel in the upper half straddles into the next word, so it needs two words held.
    assign valid = (count != '0) && (comp || !off || (count > CW'(1)));

    // run keeps the request line low until the first edge after reset release.
    assign req_o      = run && (count < FULL) && !redirect_i;
    assign req_addr_o = fetch_addr;
    assign req_kill_o = redirect_i;

    assign push      = ack_i && req_o;
    assign pop       = valid && instr_ready_i;
    assign free_head = pop && (!comp || off);

    assign instr_valid_o   = valid;
    assign instr_is_comp_o = valid && comp;
    assign instr_pc_o      = rd_pc;
    assign count_o         = count;

    always_comb begin
        instr_o = '0;
        if (valid) begin
            if (comp)
                instr_o = {16'h0000, p0};
            else if (off)
                instr_o = {next_word[15:0], head_word[31:16]};
            else
                instr_o = head_word;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= rdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run        <= 1'b0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            rd_pc      <= PC_RESET;
            fetch_addr <= {PC_RESET[XLEN-1:2], 2'b00};
        end else begin
            run <= 1'b1;
            if (redirect_i) begin
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                rd_pc      <= {redirect_pc_i[XLEN-1:1], 1'b0};
                fetch_addr <= {redirect_pc_i[XLEN-1:2], 2'b00};
            end else begin
                if (push) begin
                    tail       <= tail + PW'(1);
                    fetch_addr <= fetch_addr + XLEN'(4);
                end
                if (pop)
                    rd_pc <= rd_pc + (comp ? XLEN'(2) : XLEN'(4));
                if (free_head)
                    head <= head + PW'(1);
                count <= count + CW'(push) - CW'(free_head);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a halfword-stream model of the fetch queue.
module tb_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] PC_RESET = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        req_o;
    logic [31:0] req_addr_o;
    logic        req_kill_o;
    logic        ack_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_is_comp_o;
    logic        instr_ready_i = 1'b0;
    logic [2:0]  count_o;

    always #5 clk = ~clk;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .req_o(req_o), .req_addr_o(req_addr_o), .req_kill_o(req_kill_o),
        .ack_i(ack_i), .rdata_i(rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_is_comp_o(instr_is_comp_o), .instr_ready_i(instr_ready_i),
        .count_o(count_o)
    );

    int errors = 0;
    int checks = 0;

    // Model: the program as a stream of halfwords starting at m_pc, plus a started flag.
    logic [15:0] hq[$];
    logic [31:0] m_pc = PC_RESET;
    bit          m_run = 1'b0;

    bit          cur_redir, cur_rdy, cur_ack;
    logic [31:0] cur_rpc, cur_dat;

    bit          e_valid, e_comp, e_req, e_req_base;
    logic [31:0] e_instr, e_addr;
    int          e_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_outputs();
        int s;
        s = hq.size();
        e_count    = (s + int'(m_pc[1])) / 2;
        e_req_base = m_run && (e_count < DEPTH);
        e_req      = e_req_base && !cur_redir;
        e_addr     = (m_pc + 32'(2 * s)) & ~32'h3;
        e_valid = 1'b0;
        e_comp  = 1'b0;
        e_instr = '0;
        if (s >= 1) begin
            if (hq[0][1:0] != 2'b11) begin
                e_valid = 1'b1;
                e_comp  = 1'b1;
                e_instr = {16'h0000, hq[0]};
            end else if (s >= 2) begin
                e_valid = 1'b1;
                e_instr = {hq[1], hq[0]};
            end
        end
    endfunction

    function automatic void model_update();
        logic [15:0] tmp;
        if (cur_redir) begin
            hq.delete();
            m_pc = cur_rpc & ~32'h1;
        end else begin
            if (e_valid && cur_rdy) begin
                tmp = hq.pop_front();
                if (!e_comp) tmp = hq.pop_front();
                m_pc = m_pc + (e_comp ? 32'd2 : 32'd4);
            end
            if (cur_ack) begin
                // After a redirect into the upper half, the lower half of the first word is not program.
                if (hq.size() == 0 && m_pc[1]) begin
                    hq.push_back(cur_dat[31:16]);
                end else begin
                    hq.push_back(cur_dat[15:0]);
                    hq.push_back(cur_dat[31:16]);
                end
            end
        end
        m_run = 1'b1;
    endfunction

    task automatic set_in(input bit redir, input logic [31:0] rpc, input bit rdy,
                          input bit ackw, input logic [31:0] d);
        cur_redir = redir; cur_rpc = rpc; cur_rdy = rdy; cur_dat = d;
        redirect_i = redir; redirect_pc_i = rpc; instr_ready_i = rdy; rdata_i = d;
        model_outputs();
        cur_ack = ackw && e_req_base;
        ack_i = cur_ack;
        #2;
    endtask

    task automatic compare();
        chk("valid", {31'b0, instr_valid_o}, {31'b0, e_valid});
        chk("count", {29'b0, count_o}, e_count);
        chk("req", {31'b0, req_o}, {31'b0, e_req});
        chk("kill", {31'b0, req_kill_o}, {31'b0, cur_redir});
        chk("pc", instr_pc_o, m_pc);
        if (e_req) chk("req_addr", req_addr_o, e_addr);
        if (e_valid) begin
            chk("instr", instr_o, e_instr);
            chk("is_comp", {31'b0, instr_is_comp_o}, {31'b0, e_comp});
        end
    endtask

    task automatic step();
        compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_count", {29'b0, count_o}, 32'd0);
        chk("rst_req", {31'b0, req_o}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        chk("rst_pc", instr_pc_o, PC_RESET);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_comp", {31'b0, instr_is_comp_o}, 32'd0);
        hq.delete();
        m_pc  = PC_RESET;
        m_run = 1'b0;
        redirect_i = 1'b0; instr_ready_i = 1'b0;
        ack_i = 1'b1; rdata_i = 32'hffff_ffff;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ack_i = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic release_checks();
        set_in(0, '0, 0, 0, '0);
        chk("rel_req_low", {31'b0, req_o}, 32'd0);
        step();
        set_in(0, '0, 0, 0, '0);
        chk("rel_req", {31'b0, req_o}, 32'd1);
        chk("rel_addr", req_addr_o, 32'h8000_0000);
        step();
    endtask

    initial begin
        bit          r, rdy, ak;
        logic [31:0] rpc, d;

        #1;
        apply_reset();
        release_checks();

        // first word after reset
        set_in(0, '0, 0, 1, 32'h0000_0013); step();
        set_in(0, '0, 0, 0, '0);
        chk("t1_valid", {31'b0, instr_valid_o}, 32'd1);
        chk("t1_instr", instr_o, 32'h0000_0013);
        chk("t1_pc", instr_pc_o, 32'h8000_0000);
        step();

        // mixed compressed / straddling stream
        set_in(1, 32'h8000_0000, 0, 0, '0); step();
        set_in(0, '0, 0, 1, 32'h0093_4501); step();
        set_in(0, '0, 0, 1, 32'h0000_0001); step();
        set_in(0, '0, 1, 0, '0);
        chk("mix0_instr", instr_o, 32'h0000_4501);
        chk("mix0_comp", {31'b0, instr_is_comp_o}, 32'd1);
        chk("mix0_pc", instr_pc_o, 32'h8000_0000);
        step();
        set_in(0, '0, 1, 0, '0);
        chk("mix1_instr", instr_o, 32'h0001_0093);
        chk("mix1_comp", {31'b0, instr_is_comp_o}, 32'd0);
        chk("mix1_pc", instr_pc_o, 32'h8000_0002);
        step();
        set_in(0, '0, 1, 0, '0);
        chk("mix2_valid", {31'b0, instr_valid_o}, 32'd1);
        chk("mix2_instr", instr_o, 32'h0000_0000);
        chk("mix2_comp", {31'b0, instr_is_comp_o}, 32'd1);
        chk("mix2_pc", instr_pc_o, 32'h8000_0006);
        step();
        set_in(0, '0, 0, 0, '0);
        chk("mix_empty", {29'b0, count_o}, 32'd0);
        step();

        // backpressure fills the queue
        set_in(1, 32'h8000_1000, 0, 0, '0); step();
        repeat (4) begin set_in(0, '0, 0, 1, 32'h0000_0013); step(); end
        set_in(0, '0, 0, 0, '0);
        chk("full_count", {29'b0, count_o}, 32'd4);
        chk("full_req", {31'b0, req_o}, 32'd0);
        step();
        set_in(0, '0, 1, 0, '0); step();
        set_in(0, '0, 0, 0, '0);
        chk("drain_req", {31'b0, req_o}, 32'd1);
        chk("drain_count", {29'b0, count_o}, 32'd3);
        chk("drain_addr", req_addr_o, 32'h8000_1010);
        step();

        // straddle starvation after redirect into the upper half
        set_in(1, 32'h8000_0002, 0, 0, '0); step();
        set_in(0, '0, 1, 1, 32'h0013_0000);
        chk("strad_addr", req_addr_o, 32'h8000_0000);
        step();
        set_in(0, '0, 1, 0, '0);
        chk("strad_wait0", {31'b0, instr_valid_o}, 32'd0);
        chk("strad_count", {29'b0, count_o}, 32'd1);
        step();
        set_in(0, '0, 1, 1, 32'h0000_0000);
        chk("strad_wait1", {31'b0, instr_valid_o}, 32'd0);
        step();
        set_in(0, '0, 0, 0, '0);
        chk("strad_valid", {31'b0, instr_valid_o}, 32'd1);
        chk("strad_instr", instr_o, 32'h0000_0013);
        chk("strad_pc", instr_pc_o, 32'h8000_0002);
        step();

        // redirect with a simultaneous ack
        set_in(1, 32'h8000_2006, 0, 1, 32'hdead_beef);
        chk("rd_req", {31'b0, req_o}, 32'd0);
        chk("rd_kill", {31'b0, req_kill_o}, 32'd1);
        step();
        set_in(0, '0, 0, 0, '0);
        chk("rd_count", {29'b0, count_o}, 32'd0);
        chk("rd_valid", {31'b0, instr_valid_o}, 32'd0);
        chk("rd_addr", req_addr_o, 32'h8000_2004);
        chk("rd_pc", instr_pc_o, 32'h8000_2006);
        step();

        // randomized traffic with an asynchronous reset pulse mid-burst
        for (int i = 0; i < 2500; i++) begin
            r   = ($urandom_range(0, 31) == 0);
            rpc = 32'h8000_0000 + ($urandom_range(0, 127) << 1);
            rdy = ($urandom_range(0, 9) < 7);
            ak  = ($urandom_range(0, 9) < 6);
            d   = $urandom();
            if ($urandom_range(0, 1) == 1) d[17:16] = 2'b11;
            set_in(r, rpc, rdy, ak, d);
            if (i == 1200) begin
                apply_reset();
                release_checks();
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised successor to the single-register PC fetch stage. It decouples the instruction cache from decode with a DEPTH-entry queue of 32-bit fetch words and keeps one request in flight, so the cache can run ahead of a stalled decode stage. It extracts 16-bit compressed and 32-bit instructions at any halfword alignment, including 32-bit instructions that straddle two fetch words, and tags each with its PC. It sits between the icache/MMU request path and the ID stage, and takes redirects from the CSR and EXE feedback paths.

## Interface
- XLEN, 32: address and PC width.
- DEPTH, 4: queue entries, in 32-bit words; power of two, ≥2.
- PC_RESET, 32'h8000_0000: PC after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- redirect_i  in  1  flush everything and restart fetch at redirect_pc_i.
- redirect_pc_i  in  XLEN  new PC; bit 0 is ignored and treated as 0.
- req_o  out  1  icache fetch request.
- req_addr_o  out  XLEN  word-aligned fetch address; [1:0]=0.
- req_kill_o  out  1  kill the in-flight icache request; equals redirect_i.
- ack_i  in  1  icache response valid for the current request.
- rdata_i  in  32  icache response word.
- instr_valid_o  out  1  instr_o, instr_pc_o and instr_is_comp_o are valid.
- instr_o  out  32  instruction; a compressed instruction sits in [15:0] with [31:16]=0.
- instr_pc_o  out  XLEN  PC of instr_o.
- instr_is_comp_o  out  1  instr_o is a 16-bit instruction.
- instr_ready_i  in  1  decode accepts instr_o.
- count_o  out  $clog2(DEPTH+1)  number of queue words currently held.

## Operation
- State:
  - fetch_addr: word address of the next request.
  - rd_pc: halfword-aligned PC of the next instruction; off = rd_pc[1].
  - Circular buffer with head/tail pointers and a count.
- Request side:
  - req_o = (count < DEPTH) & ~redirect_i; req_addr_o = fetch_addr.
  - The requester holds req_o/req_addr_o stable until ack_i.
  - Only one request is outstanding at a time.
  - On ack_i & req_o & ~redirect_i: push rdata_i at tail and advance fetch_addr by 4.
  - A request is issued only when count < DEPTH, so the queue never overflows.
- Extraction (combinational from the head, with head+1 as next):
  - p0 = off ? head[31:16] : head[15:0].
  - Compressed if p0[1:0] != 2'b11: instr_o = {16'b0, p0}; valid when count ≥ 1.
  - 32-bit with off=0: instr_o = head; valid when count ≥ 1.
  - 32-bit with off=1: instr_o = {next[15:0], head[31:16]}; valid only when count ≥ 2.
- Pop on instr_valid_o & instr_ready_i:
  - rd_pc advances by 2 (compressed) or 4 (32-bit).
  - The head word is released when the consumed bytes reach or cross its end: compressed with off=1, or any 32-bit instruction. Otherwise the head is kept.
- Push and pop in the same cycle: count is unchanged and both pointers move.
- Redirect (highest priority; overrides push and pop in that cycle):
  - count, head and tail clear.
  - rd_pc = {redirect_pc_i[XLEN-1:1], 1'b0}; fetch_addr = {redirect_pc_i[XLEN-1:2], 2'b00}.
  - An ack_i in the redirect cycle is dropped.
  - The icache issues no ack_i for a killed request.
- Pointers wrap modulo DEPTH; count saturates at neither end by construction.

## Timing
- Reset values:
  - req_o=0 while rst_n=0.
  - instr_valid_o=0, count_o=0, instr_pc_o=PC_RESET, instr_o=32'h0, instr_is_comp_o=0.
  - First request, at PC_RESET, appears in the first cycle after deassertion.
- Latency: ack_i in cycle n gives instr_valid_o in cycle n+1. There is no bypass.
- Throughput: with same-cycle acks, one word per cycle; the next request is issued in cycle n+1.
- Redirect in cycle n:
  - req_o=0 and req_kill_o=1 in cycle n.
  - The new request is issued in cycle n+1.
  - instr_valid_o=0 from cycle n+1 until a new ack.
- Reset asserted mid-operation: all state clears immediately and asynchronously, and any in-flight response is discarded.

## Test plan
- Reset release: req_o=1 with req_addr_o=32'h8000_0000 one cycle after deassertion. Ack 32'h0000_0013 → instr_valid_o=1, instr_o=32'h13, instr_pc_o=32'h8000_0000.
- Mixed stream: words 32'h0093_4501 then 32'h0000_0001 →
  - c.li 16'h4501 at PC 0x8000_0000;
  - straddling 32-bit instruction 32'h0001_0093 at 0x8000_0002;
  - compressed 16'h0000 at 0x8000_0006.
- Backpressure: instr_ready_i=0 with DEPTH=4 → count_o reaches 4 and req_o drops. A single pop of a 32-bit instruction gives req_o=1 in the next cycle.
- Straddle starvation: redirect to 0x8000_0002 with a 32-bit parcel there and one word buffered → instr_valid_o stays 0 until the second ack.
- Redirect with a simultaneous ack: ack in the redirect cycle is dropped, count_o=0 next cycle, req_addr_o=word address of redirect_pc_i.
- Async reset pulse mid-burst: count_o=0 and req_o=0 immediately; fetch restarts at PC_RESET after release.
